// File: rtl/booth_encoder_1_7_pkg.sv
// Shared constants for the 16x16 radix-4 Booth multiplier.
`timescale 1ns/1ps
package booth_encoder_1_7_pkg;

    // Operand width and number of radix-4 digits it splits into.
    localparam int WIDTH = 16;
    localparam int NDIG  = 8;

    // Partial-product select codes, packed as {X, X_2, Comp}.
    localparam logic [2:0] SEL_ZERO = 3'b000;  // d = 0
    localparam logic [2:0] SEL_POS1 = 3'b100;  // d = +1
    localparam logic [2:0] SEL_POS2 = 3'b010;  // d = +2
    localparam logic [2:0] SEL_NEG2 = 3'b011;  // d = -2
    localparam logic [2:0] SEL_NEG1 = 3'b101;  // d = -1
    localparam logic [2:0] SEL_NEG0 = 3'b001;  // d = -0, row wraps to 0 after ~0 + 1

endpackage

// File: rtl/booth_encode_core.sv
// Pure combinational Booth digit encoder. The digit-0 encoder uses this same
// core with B_i0 tied low.
`timescale 1ns/1ps
module booth_encode_core (
    input  logic B_i2,
    input  logic B_i1,
    input  logic B_i0,
    output logic X,
    output logic X_2,
    output logic Comp
);

    // All three selects come from one process so they always change together.
    always_comb begin
        X    = B_i1 ^ B_i0;
        X_2  = (B_i2 & ~B_i1 & ~B_i0) | (~B_i2 & B_i1 & B_i0);
        Comp = B_i2;
    end

endmodule

// File: rtl/booth_encoder_1_7.sv
// Booth digit encoder for digit positions 1..7, window {B[2i+1], B[2i], B[2i-1]},
// with an optional output register stage.
`timescale 1ns/1ps
module booth_encoder_1_7
    import booth_encoder_1_7_pkg::*;
#(
    parameter int REG_OUT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic B_i2,
    input  logic B_i1,
    input  logic B_i0,
    output logic X,
    output logic X_2,
    output logic Comp
);

    logic x_c;
    logic x2_c;
    logic comp_c;

    booth_encode_core u_core (
        .B_i2 (B_i2),
        .B_i1 (B_i1),
        .B_i0 (B_i0),
        .X    (x_c),
        .X_2  (x2_c),
        .Comp (comp_c)
    );

    generate
        if (REG_OUT != 0) begin : g_reg
            // Capture the selects each cycle; reset clears them immediately.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    {X, X_2, Comp} <= SEL_ZERO;
                end else begin
                    {X, X_2, Comp} <= {x_c, x2_c, comp_c};
                end
            end
        end else begin : g_comb
            // Clock and reset are intentionally ignored in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign {X, X_2, Comp} = {x_c, x2_c, comp_c};
        end
    endgenerate

`ifndef SYNTHESIS
    // Selecting both A and 2A would corrupt the partial-product row.
    always_comb begin
        assert (!(X && X_2))
            else $error("booth_encoder_1_7: X and X_2 asserted together");
    end
`endif

endmodule

// File: tb/tb_booth_encoder_1_7.sv
// Directed bench for booth_encoder_1_7 in both combinational and registered builds.
`timescale 1ns/1ps
module tb_booth_encoder_1_7;

    logic clk;
    logic rst_n;

    logic c_b2, c_b1, c_b0;
    logic c_x, c_x2, c_comp;

    logic r_b2, r_b1, r_b0;
    logic r_x, r_x2, r_comp;

    int checks = 0;
    int errors = 0;

    // Hand-derived {X, X_2, Comp} for input {B_i2, B_i1, B_i0} = index.
    logic [2:0] exp_tab [8];

    booth_encoder_1_7 #(.REG_OUT(0)) dut_comb (
        .clk  (clk),
        .rst_n(rst_n),
        .B_i2 (c_b2),
        .B_i1 (c_b1),
        .B_i0 (c_b0),
        .X    (c_x),
        .X_2  (c_x2),
        .Comp (c_comp)
    );

    booth_encoder_1_7 #(.REG_OUT(1)) dut_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .B_i2 (r_b2),
        .B_i1 (r_b1),
        .B_i0 (r_b0),
        .X    (r_x),
        .X_2  (r_x2),
        .Comp (r_comp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        logic [2:0] code;

        exp_tab[0] = 3'b000;
        exp_tab[1] = 3'b100;
        exp_tab[2] = 3'b100;
        exp_tab[3] = 3'b010;
        exp_tab[4] = 3'b011;
        exp_tab[5] = 3'b101;
        exp_tab[6] = 3'b101;
        exp_tab[7] = 3'b001;

        rst_n = 1'b0;
        {c_b2, c_b1, c_b0} = 3'b000;
        {r_b2, r_b1, r_b0} = 3'b000;

        // Combinational sweep: B_i0 toggles every 100, B_i1 every 200, B_i2 every 400.
        for (int k = 0; k < 20; k++) begin
            code = k[2:0];
            {c_b2, c_b1, c_b0} = code;
            #50;
            chk($sformatf("comb_code_%b", code), {c_x, c_x2, c_comp}, exp_tab[code]);
            chk($sformatf("comb_mutex_%b", code), {2'b00, c_x & c_x2}, 3'b000);
            #50;
        end

        // Explicit boundary codes on the combinational build.
        {c_b2, c_b1, c_b0} = 3'b111;
        #1;
        chk("comb_neg_zero", {c_x, c_x2, c_comp}, 3'b001);
        {c_b2, c_b1, c_b0} = 3'b000;
        #1;
        chk("comb_zero", {c_x, c_x2, c_comp}, 3'b000);

        // Registered build: outputs held at zero through reset and clock edges.
        @(negedge clk);
        {r_b2, r_b1, r_b0} = 3'b111;
        @(posedge clk);
        #1;
        chk("reg_in_reset", {r_x, r_x2, r_comp}, 3'b000);

        @(negedge clk);
        {r_b2, r_b1, r_b0} = 3'b000;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reg_after_release", {r_x, r_x2, r_comp}, 3'b000);

        // Latency: 101 applied before an edge appears only after it.
        @(negedge clk);
        {r_b2, r_b1, r_b0} = 3'b101;
        #1;
        chk("reg_lat_before", {r_x, r_x2, r_comp}, 3'b000);
        @(posedge clk);
        #1;
        chk("reg_lat_after", {r_x, r_x2, r_comp}, 3'b101);
        {r_b2, r_b1, r_b0} = 3'b010;
        #3;
        chk("reg_hold_no_edge", {r_x, r_x2, r_comp}, 3'b101);
        @(posedge clk);
        #1;
        chk("reg_next_edge", {r_x, r_x2, r_comp}, 3'b100);

        // Every code through the register stage.
        for (int k = 0; k < 8; k++) begin
            code = k[2:0];
            @(negedge clk);
            {r_b2, r_b1, r_b0} = code;
            @(posedge clk);
            #1;
            chk($sformatf("reg_code_%b", code), {r_x, r_x2, r_comp}, exp_tab[code]);
            chk($sformatf("reg_mutex_%b", code), {2'b00, r_x & r_x2}, 3'b000);
        end

        // Asynchronous reset from a held -2 select.
        @(negedge clk);
        {r_b2, r_b1, r_b0} = 3'b100;
        @(posedge clk);
        #1;
        chk("reg_hold_neg2", {r_x, r_x2, r_comp}, 3'b011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reg_async_clear", {r_x, r_x2, r_comp}, 3'b000);
        @(posedge clk);
        #1;
        chk("reg_reset_held", {r_x, r_x2, r_comp}, 3'b000);

        @(negedge clk);
        {r_b2, r_b1, r_b0} = 3'b001;
        rst_n = 1'b1;
        #1;
        chk("reg_release_pre_edge", {r_x, r_x2, r_comp}, 3'b000);
        @(posedge clk);
        #1;
        chk("reg_first_capture", {r_x, r_x2, r_comp}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
